arbitro_alu: RTL
================

# arbitro_alu

Two-requester round-robin arbiter that shares the single 64-bit `ALU` between independent clients (e.g. the execute stage and an address-generation/branch unit). Each requester hands over an operand pair and an `aluOP` with a valid/ready handshake. The block sequences one operation at a time through the ALU, registers `resultadoALU` and `zero`, and returns them to the winning requester with a valid/ready response handshake.

## Interface
- `ANCHO`, 64, datapath width; must match the ALU width.
- `clk`  in  1  single clock, rising-edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid[1:0]`  in  2  request valid, one bit per requester.
- `req_ready[1:0]`  out  2  request accepted this cycle; at most one bit set.
- `datoRN0`, `datoRM0`  in  ANCHO  requester 0 operands.
- `aluOP0`  in  3  requester 0 operation.
- `datoRN1`, `datoRM1`  in  ANCHO  requester 1 operands.
- `aluOP1`  in  3  requester 1 operation.
- `resp_valid[1:0]`  out  2  response valid, one-hot to the owner of the result.
- `resp_ready[1:0]`  in  2  requester consumes the response.
- `resultado`  out  ANCHO  registered ALU result.
- `zero`  out  1  registered ALU zero flag.

## Operation
- FSM states: `LIBRE` (idle), `EJECUTA`, `RESPONDE`. Reset state is `LIBRE`.
- `LIBRE`:
  - Grant goes to the valid requester. If both are valid, grant goes to the one selected by priority pointer `prio`; `prio` resets to 0.
  - `req_ready[g]` = 1 combinationally for the granted requester `g` only.
  - On the handshake (`req_valid[g] && req_ready[g]`): latch `datoRN`, `datoRM`, `aluOP` of `g` and the owner id, then go to `EJECUTA`.
- `EJECUTA`: the ALU is driven from the latched operands. At the clock edge, capture `resultadoALU` into `resultado` and `zero` into `zero`, then go to `RESPONDE`.
- `RESPONDE`:
  - `resp_valid[owner]` = 1; `resultado` and `zero` are held stable.
  - When `resp_ready[owner]` = 1: go to `LIBRE` and set `prio` = ~owner.
  - `resp_ready` of the non-owner is ignored.
- `req_ready` = 0 in `EJECUTA` and `RESPONDE`. A requester must hold `req_valid` and its operands until accepted.
- A requester may drop `req_valid` before it is granted; this has no side effect.
- The arbiter does not modify operands or results: ALU width and overflow rules apply unchanged.
- Reset mid-operation aborts the transaction. The pending response is lost, and `prio` returns to 0.

## Timing
- Reset values: `req_ready` = 0, `resp_valid` = 0, `resultado` = 0, `zero` = 0, state `LIBRE`, `prio` = 0.
- Accept in cycle N, then `EJECUTA` in N+1, then `resp_valid` high from N+2 on.
- With `resp_ready` held at 1, the minimum spacing is 3 cycles per operation. A new accept is possible in the cycle after the response handshake.
- `resp_valid` stays high until consumed; back-pressure has no time limit.
- `req_ready` depends combinationally on `req_valid` and state only, never on `resp_ready`.

## Configuration
- `ARBITRO_ALU_STATS_EN`
  - Defined: adds outputs `cuenta0` and `cuenta1` (16 bits each). Each counts accepted requests per requester, saturates at 16'hFFFF, and resets to 0.
  - Undefined: these ports and counters do not exist. All other behaviour is identical.

## Structure
- The shared package holds:
  - FSM state encoding constants (`LIBRE`, `EJECUTA`, `RESPONDE`).
  - ALU opcode constants: 3'b000 AND, 3'b001 OR, 3'b010 ADD, 3'b110 SUB.
  - The `ANCHO` default.
- Single sub-module: one instance of `ALU`, driven by the latched operand registers.

## Test plan
- Requester 0 only, `datoRN0`=10, `datoRM0`=3, `aluOP0`=ADD, `resp_ready`=1 -> accept in cycle N; `resp_valid`=2'b01 in N+2; `resultado`=13, `zero`=0.
- Both requesters valid after reset: req0 SUB 10-3, req1 SUB 5-5 -> req0 granted first (`resultado`=7, `zero`=0); req1 granted next (`resultado`=0, `zero`=1, `resp_valid`=2'b10).
- Both requesters held valid for 4 operations -> grant order 0,1,0,1; `req_ready` never 2'b11.
- `resp_ready`=0 for 5 cycles in `RESPONDE` -> `resp_valid` and `resultado` stable; `req_ready`=0 even with requests pending. After release, the next accept happens one cycle later.
- `reset` asserted during `EJECUTA` -> all outputs 0 immediately; next contention grants requester 0.
- With `ARBITRO_ALU_STATS_EN`: 3 grants to req0 and 2 to req1 -> `cuenta0`=3, `cuenta1`=2. Preload near 16'hFFFF -> counter saturates at 16'hFFFF.

Source files
------------

// File: rtl/arbitro_alu_pkg.sv
// Shared definitions for the two-requester ALU arbiter.
// Holds the FSM state encoding, the ALU opcode constants and the default datapath width.
// Imported by the interface, the ALU and the arbiter top.
package arbitro_alu_pkg;

    localparam int ANCHO_DEF = 64;

    typedef enum logic [1:0] {
        LIBRE    = 2'd0,
        EJECUTA  = 2'd1,
        RESPONDE = 2'd2
    } estado_t;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;

    // One-hot response vector for a given owner id.
    function automatic logic [1:0] onehot_owner(input logic owner);
        return owner ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/arbitro_alu_if.sv
// Request/response bundle between the two ALU clients and the arbiter.
// master = requester side (drives operands, req_valid, resp_ready).
// slave  = arbiter side (drives req_ready, resp_valid, resultado, zero).
interface arbitro_alu_if #(
    parameter int ANCHO = arbitro_alu_pkg::ANCHO_DEF
);
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [ANCHO-1:0] datoRN0;
    logic [ANCHO-1:0] datoRM0;
    logic [2:0]       aluOP0;
    logic [ANCHO-1:0] datoRN1;
    logic [ANCHO-1:0] datoRM1;
    logic [2:0]       aluOP1;
    logic [1:0]       resp_valid;
    logic [1:0]       resp_ready;
    logic [ANCHO-1:0] resultado;
    logic             zero;

    modport master (
        output req_valid, datoRN0, datoRM0, aluOP0, datoRN1, datoRM1, aluOP1, resp_ready,
        input  req_ready, resp_valid, resultado, zero
    );

    modport slave (
        input  req_valid, datoRN0, datoRM0, aluOP0, datoRN1, datoRM1, aluOP1, resp_ready,
        output req_ready, resp_valid, resultado, zero
    );
endinterface

// File: rtl/arbitro_alu_alu.sv
// Combinational 64-bit ALU: AND, OR, ADD, SUB; unknown opcodes yield 0.
// Latency: zero cycles (purely combinational).
// Backpressure: none; results wrap at ANCHO bits, no overflow flag.
module ALU
    import arbitro_alu_pkg::*;
#(
    parameter int ANCHO = ANCHO_DEF
) (
    input  logic [ANCHO-1:0] datoRN,
    input  logic [ANCHO-1:0] datoRM,
    input  logic [2:0]       aluOP,
    output logic [ANCHO-1:0] resultadoALU,
    output logic             zero
);

    // Opcode decode and zero detect.
    always_comb begin
        resultadoALU = '0;
        case (aluOP)
            ALU_AND: resultadoALU = datoRN & datoRM;
            ALU_OR:  resultadoALU = datoRN | datoRM;
            ALU_ADD: resultadoALU = datoRN + datoRM;
            ALU_SUB: resultadoALU = datoRN - datoRM;
            default: resultadoALU = '0;
        endcase
        zero = (resultadoALU == '0);
    end

endmodule

// File: rtl/arbitro_alu.sv
// Round-robin arbiter sharing one ALU between two requesters (optional macro ARBITRO_ALU_STATS_EN adds per-requester accept counters).
// Latency: accept in N, execute in N+1, resp_valid from N+2; one op in flight, 3 cycles minimum per op.
// Backpressure: resp_valid holds indefinitely until the owner's resp_ready; req_ready stays low meanwhile.
module arbitro_alu
    import arbitro_alu_pkg::*;
#(
    parameter int ANCHO = ANCHO_DEF
) (
    input  logic clk,
    input  logic reset,
    arbitro_alu_if.slave bus
`ifdef ARBITRO_ALU_STATS_EN
    ,
    output logic [15:0] cuenta0,
    output logic [15:0] cuenta1
`endif
);

    estado_t          estado;
    estado_t          estado_sig;
    logic             prio;
    logic             owner;
    logic             gnt;
    logic             acepta;
    logic             resp_hs;
    logic [1:0]       req_ready;
    logic [ANCHO-1:0] op_rn;
    logic [ANCHO-1:0] op_rm;
    logic [2:0]       op_alu;
    logic [ANCHO-1:0] alu_res;
    logic             alu_zero;
    logic [ANCHO-1:0] resultado_q;
    logic             zero_q;

    ALU #(.ANCHO(ANCHO)) u_alu (
        .datoRN       (op_rn),
        .datoRM       (op_rm),
        .aluOP        (op_alu),
        .resultadoALU (alu_res),
        .zero         (alu_zero)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) estado <= LIBRE;
        else       estado <= estado_sig;
    end

    // Grant selection, handshakes and next state; req_ready never looks at resp_ready.
    always_comb begin
        estado_sig = estado;
        req_ready  = 2'b00;
        acepta     = 1'b0;
        resp_hs    = 1'b0;
        // Contention goes to the priority pointer, otherwise to whoever is valid.
        gnt        = (&bus.req_valid) ? prio : bus.req_valid[1];
        case (estado)
            LIBRE: begin
                if (|bus.req_valid) begin
                    req_ready[gnt] = 1'b1;
                    acepta         = 1'b1;
                    estado_sig     = EJECUTA;
                end
            end
            EJECUTA: begin
                estado_sig = RESPONDE;
            end
            RESPONDE: begin
                if (bus.resp_ready[owner]) begin
                    resp_hs    = 1'b1;
                    estado_sig = LIBRE;
                end
            end
            default: estado_sig = LIBRE;
        endcase
    end

    // Operand capture on accept, result capture in EJECUTA, pointer update on response handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio        <= 1'b0;
            owner       <= 1'b0;
            op_rn       <= '0;
            op_rm       <= '0;
            op_alu      <= '0;
            resultado_q <= '0;
            zero_q      <= 1'b0;
        end else begin
            if (acepta) begin
                owner  <= gnt;
                op_rn  <= gnt ? bus.datoRN1 : bus.datoRN0;
                op_rm  <= gnt ? bus.datoRM1 : bus.datoRM0;
                op_alu <= gnt ? bus.aluOP1  : bus.aluOP0;
            end
            if (estado == EJECUTA) begin
                resultado_q <= alu_res;
                zero_q      <= alu_zero;
            end
            if (resp_hs) prio <= ~owner;
        end
    end

    assign bus.req_ready  = req_ready;
    assign bus.resp_valid = (estado == RESPONDE) ? onehot_owner(owner) : 2'b00;
    assign bus.resultado  = resultado_q;
    assign bus.zero       = zero_q;

`ifdef ARBITRO_ALU_STATS_EN
    // Saturating per-requester accept counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cuenta0 <= '0;
            cuenta1 <= '0;
        end else if (acepta) begin
            if (!gnt && cuenta0 != 16'hFFFF) cuenta0 <= cuenta0 + 16'd1;
            if (gnt  && cuenta1 != 16'hFFFF) cuenta1 <= cuenta1 + 16'd1;
        end
    end
`endif

endmodule
